// File: rtl/rob_multi_wb_if.sv
// Bus bundle for rob_multi_wb: allocation, operand lookup, writeback channels,
// commit, predictor update and rollback. The ROB takes the slave modport.
interface rob_multi_wb_if #(
    parameter int ID_W     = 5,
    parameter int WB_PORTS = 2
);
    logic                     alloc_en;
    logic [4:0]               alloc_rd;
    logic [31:0]              alloc_pc;
    logic                     alloc_is_br;
    logic                     alloc_pred;
    logic [31:0]              alloc_rbk_pc;
    logic [ID_W-1:0]          alloc_id;

    logic [ID_W-1:0]          q1_id;
    logic [ID_W-1:0]          q2_id;
    logic                     q1_rdy;
    logic                     q2_rdy;
    logic [31:0]              v1;
    logic [31:0]              v2;

    logic [WB_PORTS-1:0]      wb_valid;
    logic [WB_PORTS*ID_W-1:0] wb_id;
    logic [WB_PORTS*32-1:0]   wb_data;
    logic [WB_PORTS-1:0]      wb_taken;
    logic [WB_PORTS*32-1:0]   wb_target;

    logic                     full_o;
    logic                     commit_o;
    logic [4:0]               commit_rd;
    logic [ID_W-1:0]          commit_id;
    logic [31:0]              commit_data;
    logic                     pdt_en;
    logic                     pdt_taken;
    logic [31:0]              pdt_pc;
    logic                     rollback_o;
    logic [31:0]              rollback_pc;

    modport master (
        output alloc_en, alloc_rd, alloc_pc, alloc_is_br, alloc_pred, alloc_rbk_pc,
        output q1_id, q2_id,
        output wb_valid, wb_id, wb_data, wb_taken, wb_target,
        input  alloc_id, q1_rdy, q2_rdy, v1, v2, full_o,
        input  commit_o, commit_rd, commit_id, commit_data,
        input  pdt_en, pdt_taken, pdt_pc, rollback_o, rollback_pc
    );

    modport slave (
        input  alloc_en, alloc_rd, alloc_pc, alloc_is_br, alloc_pred, alloc_rbk_pc,
        input  q1_id, q2_id,
        input  wb_valid, wb_id, wb_data, wb_taken, wb_target,
        output alloc_id, q1_rdy, q2_rdy, v1, v2, full_o,
        output commit_o, commit_rd, commit_id, commit_data,
        output pdt_en, pdt_taken, pdt_pc, rollback_o, rollback_pc
    );
endinterface

// File: rtl/rob_multi_wb.sv
// Reorder buffer with WB_PORTS writeback channels, in-order single retire and lookup bypass.
// Optional ROB_PERF_CNT_EN adds saturating retire/branch/mispredict counters.
module rob_multi_wb #(
    parameter int DEPTH     = 16,
    parameter int ID_W      = 5,
    parameter int WB_PORTS  = 2,
    parameter int AFULL_GAP = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]    perf_retired,
    output logic [31:0]    perf_branches,
    output logic [31:0]    perf_mispred,
`endif
    rob_multi_wb_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;

    logic [4:0]       ent_rd     [DEPTH];
    logic [31:0]      ent_pc     [DEPTH];
    logic [31:0]      ent_rbk_pc [DEPTH];
    logic [31:0]      ent_data   [DEPTH];
    logic [31:0]      ent_target [DEPTH];
    logic [DEPTH-1:0] ent_is_br;
    logic [DEPTH-1:0] ent_pred;
    logic [DEPTH-1:0] ent_taken;

    logic [WB_PORTS-1:0] wb_valid;
    logic [WB_PORTS-1:0] wb_taken;
    logic [WB_PORTS-1:0] wb_hit;
    logic [ID_W-1:0]     wb_id     [WB_PORTS];
    logic [AW-1:0]       wb_idx    [WB_PORTS];
    logic [31:0]         wb_data   [WB_PORTS];
    logic [31:0]         wb_target [WB_PORTS];

    logic        commit_q;
    logic [4:0]  commit_rd_q;
    logic [ID_W-1:0] commit_id_q;
    logic [31:0] commit_data_q;
    logic        pdt_en_q;
    logic        pdt_taken_q;
    logic [31:0] pdt_pc_q;
    logic        rollback_q;
    logic [31:0] rollback_pc_q;

    logic flush;
    logic retire;
    logic mispredict;
    logic alloc_ok;

    function automatic logic id_valid(input logic [ID_W-1:0] id);
        return (id != '0) && (id <= ID_W'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] id2idx(input logic [ID_W-1:0] id);
        return AW'(id - ID_W'(1));
    endfunction

    // Ready entries return stored data; otherwise the highest matching live writeback is forwarded.
    function automatic logic [32:0] lookup(input logic [ID_W-1:0] id);
        logic [32:0]   res;
        logic [AW-1:0] idx;
        res = '0;
        idx = id2idx(id);
        if (id_valid(id)) begin
            if (ready[idx]) begin
                res = {1'b1, ent_data[idx]};
            end else begin
                for (int c = 0; c < WB_PORTS; c++) begin
                    if (wb_hit[c] && (wb_id[c] == id)) begin
                        res = {1'b1, wb_data[c]};
                    end
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        wb_valid = bus.wb_valid;
        wb_taken = bus.wb_taken;
        wb_hit   = '0;
        for (int c = 0; c < WB_PORTS; c++) begin
            wb_id[c]     = bus.wb_id[c*ID_W +: ID_W];
            wb_data[c]   = bus.wb_data[c*32 +: 32];
            wb_target[c] = bus.wb_target[c*32 +: 32];
            wb_idx[c]    = id2idx(wb_id[c]);
            wb_hit[c]    = wb_valid[c] && id_valid(wb_id[c]) && busy[wb_idx[c]];
        end
    end

    // A pending rollback pulse turns the whole cycle into a flush.
    assign flush      = rdy && rollback_q;
    assign retire     = rdy && !rollback_q && busy[head] && ready[head];
    assign mispredict = ent_is_br[head] && (ent_taken[head] ^ ent_pred[head]);
    assign alloc_ok   = rdy && !rollback_q && bus.alloc_en && (count != CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            ready <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            ready <= '0;
        end else if (rdy) begin
            for (int c = 0; c < WB_PORTS; c++) begin
                if (wb_hit[c]) begin
                    ready[wb_idx[c]] <= 1'b1;
                end
            end
            if (retire) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                head        <= head + AW'(1);
            end
            if (alloc_ok) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
                tail        <= tail + AW'(1);
            end
            count <= count + CW'(alloc_ok) - CW'(retire);
        end
    end

    // Payload is only read behind busy/ready, so it needs no reset; later channels override earlier ones.
    always_ff @(posedge clk) begin
        if (rdy && !rollback_q) begin
            for (int c = 0; c < WB_PORTS; c++) begin
                if (wb_hit[c]) begin
                    ent_data[wb_idx[c]]   <= wb_data[c];
                    ent_taken[wb_idx[c]]  <= wb_taken[c];
                    ent_target[wb_idx[c]] <= wb_target[c];
                end
            end
            if (alloc_ok) begin
                ent_rd[tail]     <= bus.alloc_rd;
                ent_pc[tail]     <= bus.alloc_pc;
                ent_is_br[tail]  <= bus.alloc_is_br;
                ent_pred[tail]   <= bus.alloc_pred;
                ent_rbk_pc[tail] <= bus.alloc_rbk_pc;
                ent_data[tail]   <= '0;
                ent_taken[tail]  <= 1'b0;
                ent_target[tail] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_q      <= 1'b0;
            commit_rd_q   <= '0;
            commit_id_q   <= '0;
            commit_data_q <= '0;
            pdt_en_q      <= 1'b0;
            pdt_taken_q   <= 1'b0;
            pdt_pc_q      <= '0;
            rollback_q    <= 1'b0;
            rollback_pc_q <= '0;
        end else if (rdy) begin
            commit_q   <= retire && (ent_rd[head] != 5'd0);
            pdt_en_q   <= retire && ent_is_br[head];
            rollback_q <= retire && mispredict;
            if (retire) begin
                commit_rd_q   <= ent_rd[head];
                commit_id_q   <= ID_W'(head) + ID_W'(1);
                commit_data_q <= ent_data[head];
                pdt_taken_q   <= ent_taken[head];
                pdt_pc_q      <= ent_pc[head];
                if (mispredict) begin
                    rollback_pc_q <= ent_taken[head] ? ent_target[head] : ent_rbk_pc[head];
                end
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Counters survive rollback; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_retired  <= '0;
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else begin
            if (retire && (perf_retired != '1)) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (retire && ent_is_br[head] && (perf_branches != '1)) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (retire && mispredict && (perf_mispred != '1)) begin
                perf_mispred <= perf_mispred + 32'd1;
            end
        end
    end
`endif

    always_comb begin
        {bus.q1_rdy, bus.v1} = lookup(bus.q1_id);
        {bus.q2_rdy, bus.v2} = lookup(bus.q2_id);
    end

    assign bus.alloc_id    = ID_W'(tail) + ID_W'(1);
    assign bus.full_o      = count >= CW'(DEPTH - AFULL_GAP);
    assign bus.commit_o    = commit_q;
    assign bus.commit_rd   = commit_rd_q;
    assign bus.commit_id   = commit_id_q;
    assign bus.commit_data = commit_data_q;
    assign bus.pdt_en      = pdt_en_q;
    assign bus.pdt_taken   = pdt_taken_q;
    assign bus.pdt_pc      = pdt_pc_q;
    assign bus.rollback_o  = rollback_q;
    assign bus.rollback_pc = rollback_pc_q;
endmodule

// File: tb/tb_rob_multi_wb.sv
// Directed self-checking bench for rob_multi_wb (DEPTH=16, ID_W=5, WB_PORTS=2, AFULL_GAP=4).
module tb_rob_multi_wb;
    logic clk;
    logic rst;
    logic rdy;
    int   checks;
    int   failures;

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_retired, perf_branches, perf_mispred;
`endif

    rob_multi_wb_if #(.ID_W(5), .WB_PORTS(2)) bus ();

    rob_multi_wb #(.DEPTH(16), .ID_W(5), .WB_PORTS(2), .AFULL_GAP(4)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
`ifdef ROB_PERF_CNT_EN
        .perf_retired(perf_retired),
        .perf_branches(perf_branches),
        .perf_mispred(perf_mispred),
`endif
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rdy              = 1'b1;
        bus.alloc_en     = 1'b0;
        bus.alloc_rd     = '0;
        bus.alloc_pc     = '0;
        bus.alloc_is_br  = 1'b0;
        bus.alloc_pred   = 1'b0;
        bus.alloc_rbk_pc = '0;
        bus.q1_id        = '0;
        bus.q2_id        = '0;
        bus.wb_valid     = '0;
        bus.wb_id        = '0;
        bus.wb_data      = '0;
        bus.wb_taken     = '0;
        bus.wb_target    = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic set_alloc(input logic [4:0] rd, input logic [31:0] pc, input logic is_br,
                             input logic pred, input logic [31:0] rbk);
        bus.alloc_en     = 1'b1;
        bus.alloc_rd     = rd;
        bus.alloc_pc     = pc;
        bus.alloc_is_br  = is_br;
        bus.alloc_pred   = pred;
        bus.alloc_rbk_pc = rbk;
    endtask

    task automatic alloc_one(input logic [4:0] rd, input logic [31:0] pc, input logic is_br,
                             input logic pred, input logic [31:0] rbk);
        set_alloc(rd, pc, is_br, pred, rbk);
        step();
        bus.alloc_en = 1'b0;
    endtask

    task automatic set_wb(input int ch, input logic [4:0] id, input logic [31:0] data,
                          input logic taken, input logic [31:0] target);
        bus.wb_valid[ch]          = 1'b1;
        bus.wb_id[ch*5 +: 5]      = id;
        bus.wb_data[ch*32 +: 32]  = data;
        bus.wb_taken[ch]          = taken;
        bus.wb_target[ch*32 +: 32] = target;
    endtask

    task automatic wb_one(input logic [4:0] id, input logic [31:0] data);
        set_wb(0, id, data, 1'b0, 32'h0);
        step();
        bus.wb_valid = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.alloc_id !== 5'd1) begin failures++; $display("[TB] FAIL reset_alloc_id: got %0d want 1", bus.alloc_id); end
        checks++; if (bus.commit_o !== 1'b0 || bus.rollback_o !== 1'b0 || bus.pdt_en !== 1'b0 || bus.full_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_pulses: commit=%b rollback=%b pdt=%b full=%b want 0", bus.commit_o, bus.rollback_o, bus.pdt_en, bus.full_o); end
        for (int i = 1; i <= 3; i++) alloc_one(5'(i), 32'h100 + 32'(4*i), 1'b0, 1'b0, 32'h0);
        checks++; if (bus.alloc_id !== 5'd4) begin failures++; $display("[TB] FAIL fill3_alloc_id: got %0d want 4", bus.alloc_id); end
        wb_one(5'd1, 32'h55);
        step();
        checks++; if (bus.commit_o !== 1'b1 || bus.commit_id !== 5'd1 || bus.commit_data !== 32'h55) begin
            failures++; $display("[TB] FAIL pre_reset_commit: commit=%b id=%0d data=%h want 1/1/55", bus.commit_o, bus.commit_id, bus.commit_data); end
        rst = 1'b0;
        #2;
        checks++; if (bus.commit_o !== 1'b0 || bus.commit_id !== 5'd0 || bus.commit_data !== 32'h0 || bus.commit_rd !== 5'd0) begin
            failures++; $display("[TB] FAIL async_reset_commit: commit=%b id=%0d data=%h rd=%0d want 0", bus.commit_o, bus.commit_id, bus.commit_data, bus.commit_rd); end
        checks++; if (bus.alloc_id !== 5'd1) begin failures++; $display("[TB] FAIL async_reset_alloc_id: got %0d want 1", bus.alloc_id); end
        step();
        rst = 1'b1;
        step();
        checks++; if (bus.alloc_id !== 5'd1 || bus.commit_o !== 1'b0) begin
            failures++; $display("[TB] FAIL post_reset: alloc_id=%0d commit=%b want 1/0", bus.alloc_id, bus.commit_o); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 1; i <= 11; i++) alloc_one(5'(i), 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.full_o !== 1'b0) begin failures++; $display("[TB] FAIL full_at_11: got %b want 0", bus.full_o); end
        alloc_one(5'd12, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.full_o !== 1'b1 || bus.alloc_id !== 5'd13) begin
            failures++; $display("[TB] FAIL full_at_12: full=%b alloc_id=%0d want 1/13", bus.full_o, bus.alloc_id); end
        wb_one(5'd1, 32'hA);
        alloc_one(5'd13, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.full_o !== 1'b1 || bus.alloc_id !== 5'd14 || bus.commit_id !== 5'd1) begin
            failures++; $display("[TB] FAIL alloc_retire_same: full=%b alloc_id=%0d commit_id=%0d want 1/14/1", bus.full_o, bus.alloc_id, bus.commit_id); end
        wb_one(5'd2, 32'hB);
        step();
        checks++; if (bus.full_o !== 1'b0 || bus.commit_id !== 5'd2) begin
            failures++; $display("[TB] FAIL retire_only: full=%b commit_id=%0d want 0/2", bus.full_o, bus.commit_id); end
        for (int i = 0; i < 5; i++) alloc_one(5'd1, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.full_o !== 1'b1 || bus.alloc_id !== 5'd3) begin
            failures++; $display("[TB] FAIL fill_16: full=%b alloc_id=%0d want 1/3", bus.full_o, bus.alloc_id); end
        alloc_one(5'd1, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.alloc_id !== 5'd3) begin failures++; $display("[TB] FAIL alloc_when_full: alloc_id=%0d want 3", bus.alloc_id); end
    endtask

    task automatic test_wb_collision();
        apply_reset();
        for (int i = 1; i <= 3; i++) alloc_one(5'(i), 32'h0, 1'b0, 1'b0, 32'h0);
        set_wb(0, 5'd3, 32'h11, 1'b0, 32'h0);
        set_wb(1, 5'd3, 32'h22, 1'b0, 32'h0);
        bus.q1_id = 5'd3;
        bus.q2_id = 5'd2;
        #1;
        checks++; if (bus.q1_rdy !== 1'b1 || bus.v1 !== 32'h22) begin
            failures++; $display("[TB] FAIL bypass_collision: rdy=%b v1=%h want 1/22", bus.q1_rdy, bus.v1); end
        checks++; if (bus.q2_rdy !== 1'b0 || bus.v2 !== 32'h0) begin
            failures++; $display("[TB] FAIL lookup_not_ready: rdy=%b v2=%h want 0/0", bus.q2_rdy, bus.v2); end
        step();
        bus.wb_valid = '0;
        bus.q2_id    = 5'd0;
        #1;
        checks++; if (bus.q1_rdy !== 1'b1 || bus.v1 !== 32'h22) begin
            failures++; $display("[TB] FAIL stored_collision: rdy=%b v1=%h want 1/22", bus.q1_rdy, bus.v1); end
        checks++; if (bus.q2_rdy !== 1'b0 || bus.v2 !== 32'h0) begin
            failures++; $display("[TB] FAIL lookup_id0: rdy=%b v2=%h want 0/0", bus.q2_rdy, bus.v2); end
        set_wb(0, 5'd1, 32'hA1, 1'b0, 32'h0);
        set_wb(1, 5'd2, 32'hB2, 1'b0, 32'h0);
        step();
        bus.wb_valid = '0;
        step();
        checks++; if (bus.commit_id !== 5'd1 || bus.commit_data !== 32'hA1) begin
            failures++; $display("[TB] FAIL commit_first: id=%0d data=%h want 1/a1", bus.commit_id, bus.commit_data); end
        step();
        step();
        checks++; if (bus.commit_o !== 1'b1 || bus.commit_id !== 5'd3 || bus.commit_rd !== 5'd3 || bus.commit_data !== 32'h22) begin
            failures++; $display("[TB] FAIL commit_collision: c=%b id=%0d rd=%0d data=%h want 1/3/3/22", bus.commit_o, bus.commit_id, bus.commit_rd, bus.commit_data); end
        bus.q1_id = 5'd0;
    endtask

    task automatic test_mispredict();
        apply_reset();
        alloc_one(5'd0, 32'h200, 1'b1, 1'b0, 32'h204);
        alloc_one(5'd5, 32'h204, 1'b0, 1'b0, 32'h0);
        set_wb(0, 5'd1, 32'h0, 1'b1, 32'h1000);
        step();
        bus.wb_valid = '0;
        step();
        checks++; if (bus.rollback_o !== 1'b1 || bus.rollback_pc !== 32'h1000) begin
            failures++; $display("[TB] FAIL rollback_taken: rb=%b pc=%h want 1/1000", bus.rollback_o, bus.rollback_pc); end
        checks++; if (bus.pdt_en !== 1'b1 || bus.pdt_pc !== 32'h200 || bus.pdt_taken !== 1'b1 || bus.commit_o !== 1'b0) begin
            failures++; $display("[TB] FAIL pdt_update: en=%b pc=%h taken=%b commit=%b want 1/200/1/0", bus.pdt_en, bus.pdt_pc, bus.pdt_taken, bus.commit_o); end
        set_alloc(5'd9, 32'h208, 1'b0, 1'b0, 32'h0);
        step();
        bus.alloc_en = 1'b0;
        checks++; if (bus.rollback_o !== 1'b0 || bus.pdt_en !== 1'b0 || bus.alloc_id !== 5'd1 || bus.full_o !== 1'b0) begin
            failures++; $display("[TB] FAIL flush: rb=%b pdt=%b alloc_id=%0d full=%b want 0/0/1/0", bus.rollback_o, bus.pdt_en, bus.alloc_id, bus.full_o); end
        alloc_one(5'd0, 32'h300, 1'b1, 1'b1, 32'h304);
        set_wb(1, 5'd1, 32'h0, 1'b0, 32'h999);
        step();
        bus.wb_valid = '0;
        step();
        checks++; if (bus.rollback_o !== 1'b1 || bus.rollback_pc !== 32'h304) begin
            failures++; $display("[TB] FAIL rollback_not_taken: rb=%b pc=%h want 1/304", bus.rollback_o, bus.rollback_pc); end
        step();
        alloc_one(5'd0, 32'h400, 1'b1, 1'b1, 32'h404);
        set_wb(0, 5'd1, 32'h0, 1'b1, 32'h500);
        step();
        bus.wb_valid = '0;
        step();
        checks++; if (bus.rollback_o !== 1'b0 || bus.pdt_en !== 1'b1 || bus.pdt_pc !== 32'h400 || bus.alloc_id !== 5'd2) begin
            failures++; $display("[TB] FAIL correct_predict: rb=%b pdt=%b pc=%h alloc_id=%0d want 0/1/400/2", bus.rollback_o, bus.pdt_en, bus.pdt_pc, bus.alloc_id); end
    endtask

    task automatic test_wrap();
        logic [4:0]  exp_id;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            exp_id   = 5'((i % 16) + 1);
            exp_rd   = 5'((i % 31) + 1);
            exp_data = 32'hD000_0000 + 32'(i);
            checks++; if (bus.alloc_id !== exp_id) begin
                failures++; $display("[TB] FAIL wrap_alloc_id[%0d]: got %0d want %0d", i, bus.alloc_id, exp_id); end
            alloc_one(exp_rd, 32'(i), 1'b0, 1'b0, 32'h0);
            wb_one(exp_id, exp_data);
            step();
            checks++; if (bus.commit_o !== 1'b1 || bus.commit_id !== exp_id || bus.commit_rd !== exp_rd || bus.commit_data !== exp_data) begin
                failures++; $display("[TB] FAIL wrap_commit[%0d]: c=%b id=%0d rd=%0d data=%h want 1/%0d/%0d/%h",
                                     i, bus.commit_o, bus.commit_id, bus.commit_rd, bus.commit_data, exp_id, exp_rd, exp_data); end
        end
    endtask

    task automatic test_rd0_and_stall();
        apply_reset();
        alloc_one(5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        alloc_one(5'd7, 32'h0, 1'b0, 1'b0, 32'h0);
        wb_one(5'd1, 32'h33);
        step();
        checks++; if (bus.commit_o !== 1'b0 || bus.pdt_en !== 1'b0 || bus.alloc_id !== 5'd3) begin
            failures++; $display("[TB] FAIL rd0_retire: commit=%b pdt=%b alloc_id=%0d want 0/0/3", bus.commit_o, bus.pdt_en, bus.alloc_id); end
        wb_one(5'd2, 32'h77);
        rdy = 1'b0;
        set_alloc(5'd4, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step();
        checks++; if (bus.commit_o !== 1'b0 || bus.alloc_id !== 5'd3) begin
            failures++; $display("[TB] FAIL stall_frozen: commit=%b alloc_id=%0d want 0/3", bus.commit_o, bus.alloc_id); end
        bus.alloc_en = 1'b0;
        rdy = 1'b1;
        step();
        checks++; if (bus.commit_o !== 1'b1 || bus.commit_id !== 5'd2 || bus.commit_data !== 32'h77) begin
            failures++; $display("[TB] FAIL head_advanced: c=%b id=%0d data=%h want 1/2/77", bus.commit_o, bus.commit_id, bus.commit_data); end
        rdy = 1'b0;
        step();
        step();
        checks++; if (bus.commit_o !== 1'b1 || bus.commit_id !== 5'd2) begin
            failures++; $display("[TB] FAIL pulse_held: c=%b id=%0d want 1/2", bus.commit_o, bus.commit_id); end
        rdy = 1'b1;
        step();
        checks++; if (bus.commit_o !== 1'b0 || bus.alloc_id !== 5'd3) begin
            failures++; $display("[TB] FAIL pulse_drop: c=%b alloc_id=%0d want 0/3", bus.commit_o, bus.alloc_id); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        clear_inputs();
        test_reset();
        test_full();
        test_wb_collision();
        test_mispredict();
        test_wrap();
        test_rd0_and_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
